// File: rtl/machine_front_panel_if.sv
// Memory-side port of the front panel: address/data, write/read requests and ready handshake.
// The master modport is the panel; the slave modport is the memory it drives.
interface machine_front_panel_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) ();
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/machine_front_panel.sv
// Front-panel controller: debounced buttons and switches set a current address and
// deposit to / examine memory through a request-ready handshake.
module machine_front_panel #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic                  system1000,
  input  logic                  system1000_rstn,
  input  logic [DW-1:0]         sw,
  input  logic [4:0]            btn,
  machine_front_panel_if.master mem,
  output logic [AW-1:0]         disp_addr,
  output logic [DW-1:0]         disp_data,
  output logic                  busy
);

  localparam int unsigned CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  logic [4:0]    sync1_q, sync2_q, db_q, db_prev_q, pulse;
  logic [CW-1:0] cnt_q [5];

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] disp_q, disp_d;
  logic          we_q, we_d, re_q, re_d, busy_q;

  // Debounced level only flips after DEBOUNCE consecutive samples disagreeing with it.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          cnt_q[i] <= '0;
          db_q[i]  <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign pulse = db_q & ~db_prev_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    disp_d  = disp_q;
    we_d    = we_q;
    re_d    = re_q;
    case (state_q)
      StIdle: begin
        // Priority: deposit > examine > load > next > prev.
        if (pulse[0]) begin
          wdata_d = sw;
          we_d    = 1'b1;
          state_d = StWrite;
        end else if (pulse[3]) begin
          re_d    = 1'b1;
          state_d = StRead;
        end else if (pulse[4]) begin
          addr_d = AW'(sw);
        end else if (pulse[1]) begin
          addr_d = addr_q + AW'(1);
        end else if (pulse[2]) begin
          addr_d = addr_q - AW'(1);
        end
      end
      StWrite: begin
        if (mem.mem_ready) begin
          we_d    = 1'b0;
          disp_d  = wdata_q;
          state_d = StIdle;
          if (AUTO_INC != 0) addr_d = addr_q + AW'(1);
        end
      end
      StRead: begin
        if (mem.mem_ready) begin
          re_d    = 1'b0;
          disp_d  = mem.mem_rdata;
          state_d = StIdle;
        end
      end
      default: begin
        we_d    = 1'b0;
        re_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      disp_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      disp_q  <= disp_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_re    = re_q;
  assign disp_addr     = addr_q;
  assign disp_data     = disp_q;
  assign busy          = busy_q;

endmodule
